// File: rtl/alp_pkg.sv
// Shared encodings for the ALP controller/datapath bus: ALU ops, operand and
// load-source mux codes, and the Booth multiplication_control pairs.
package alp_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_RSUB = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_NOT  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    localparam logic [1:0] OPSEL_R0_R1  = 2'b00;
    localparam logic [1:0] OPSEL_IN_R0  = 2'b01;
    localparam logic [1:0] OPSEL_R0_ACC = 2'b10;
    localparam logic [1:0] OPSEL_ACC_Q  = 2'b11;

    localparam logic [1:0] R0SRC_IN  = 2'b00;
    localparam logic [1:0] R0SRC_ALU = 2'b01;
    localparam logic [1:0] R0SRC_R1  = 2'b10;
    localparam logic [1:0] R0SRC_ACC = 2'b11;

    localparam logic R1SRC_Q     = 1'b0;
    localparam logic R1SRC_R0    = 1'b1;
    localparam logic QSRC_HOLD   = 1'b0;
    localparam logic QSRC_R1     = 1'b1;
    localparam logic ACCSRC_ALU  = 1'b0;
    localparam logic ACCSRC_HOLD = 1'b1;

    // multiplication_control = {Q[0], G}
    localparam logic [1:0] MC_NOP_LO = 2'b00;
    localparam logic [1:0] MC_ADD    = 2'b01;
    localparam logic [1:0] MC_SUB    = 2'b10;
    localparam logic [1:0] MC_NOP_HI = 2'b11;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_RSUB);
    endfunction

endpackage

// File: rtl/alp_alu.sv
// Combinational N-bit ALU; result wraps modulo 2^N, ovf is two's-complement
// overflow for the three arithmetic ops and 0 otherwise.
module alp_alu
    import alp_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         ovf
);

    always_comb begin
        y   = a;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                y   = a + b;
                ovf = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                y   = a - b;
                ovf = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
            end
            ALU_RSUB: begin
                y   = b - a;
                ovf = (b[N-1] != a[N-1]) && (y[N-1] != b[N-1]);
            end
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOT:  y = ~a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/alp_datapath.sv
// ALP register/ALU datapath: R0, R1, Booth accumulator {ACCX,ACC}, Q and G.
// Define ALP_DP_OVF_EN to build the sticky signed-overflow flag on R0 ALU loads.
module alp_datapath
    import alp_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] DATA_IN,
    input  logic [2:0]   alu_op,
    input  logic [1:0]   operation_mux_select,
    input  logic [1:0]   r0_inputmux_select,
    input  logic         r1_inputmux_select,
    input  logic         q_inputmux_select,
    input  logic         acc_inputmux_select,
    input  logic         clr_r0,
    input  logic         clr_r1,
    input  logic         clr_acc,
    input  logic         clr_q,
    input  logic         clr_g,
    input  logic         write_r0,
    input  logic         write_r1,
    input  logic         write_g,
    input  logic         ps_acc,
    input  logic         ps_q,
    input  logic         rl_acc,
    input  logic         rl_q,
    input  logic         serial_left_acc,
    input  logic         R0_outputmux_select,
    output logic [W-1:0] DATA_OUT,
    output logic [1:0]   multiplication_control,
    output logic         r0,
    output logic         r1,
    output logic         ovf
);

    logic [W-1:0] r0_reg, r1_reg, acc_reg, q_reg;
    logic         accx_reg, g_reg;

    logic [W:0]   a_x, b_x, y_x;
    logic [W-1:0] y_w;
    logic         ovf_x, ovf_w;
    logic         unused_flags;

    // Operands are built W+1 wide (sign-extended, ACC with its ACCX guard);
    // the W-bit ALU sees the low W bits of the same selection.
    always_comb begin
        a_x = {r0_reg[W-1], r0_reg};
        b_x = {r1_reg[W-1], r1_reg};
        case (operation_mux_select)
            OPSEL_R0_R1: begin
                a_x = {r0_reg[W-1], r0_reg};
                b_x = {r1_reg[W-1], r1_reg};
            end
            OPSEL_IN_R0: begin
                a_x = {DATA_IN[W-1], DATA_IN};
                b_x = {r0_reg[W-1], r0_reg};
            end
            OPSEL_R0_ACC: begin
                a_x = {r0_reg[W-1], r0_reg};
                b_x = {accx_reg, acc_reg};
            end
            default: begin
                a_x = {accx_reg, acc_reg};
                b_x = {q_reg[W-1], q_reg};
            end
        endcase
    end

    alp_alu #(.N(W)) u_alu_w (
        .op  (alu_op),
        .a   (a_x[W-1:0]),
        .b   (b_x[W-1:0]),
        .y   (y_w),
        .ovf (ovf_w)
    );

    alp_alu #(.N(W + 1)) u_alu_x (
        .op  (alu_op),
        .a   (a_x),
        .b   (b_x),
        .y   (y_x),
        .ovf (ovf_x)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_reg   <= '0;
            r1_reg   <= '0;
            acc_reg  <= '0;
            accx_reg <= 1'b0;
            q_reg    <= '0;
            g_reg    <= 1'b0;
        end else begin
            if (clr_r0) begin
                r0_reg <= '0;
            end else if (write_r0) begin
                case (r0_inputmux_select)
                    R0SRC_IN:  r0_reg <= DATA_IN;
                    R0SRC_ALU: r0_reg <= y_w;
                    R0SRC_R1:  r0_reg <= r1_reg;
                    default:   r0_reg <= acc_reg;
                endcase
            end

            if (clr_r1) begin
                r1_reg <= '0;
            end else if (write_r1) begin
                r1_reg <= (r1_inputmux_select == R1SRC_R0) ? r0_reg : q_reg;
            end

            // {ACCX,ACC,Q} shifts right as one register; ACCX either holds
            // (arithmetic) or takes 0 (logical).
            if (clr_acc) begin
                {accx_reg, acc_reg} <= '0;
            end else if (ps_acc) begin
                if (acc_inputmux_select == ACCSRC_ALU) begin
                    {accx_reg, acc_reg} <= y_x;
                end
            end else if (rl_acc) begin
                accx_reg <= serial_left_acc ? 1'b0 : accx_reg;
                acc_reg  <= {accx_reg, acc_reg[W-1:1]};
            end

            if (clr_q) begin
                q_reg <= '0;
            end else if (ps_q) begin
                if (q_inputmux_select == QSRC_R1) begin
                    q_reg <= r1_reg;
                end
            end else if (rl_q) begin
                q_reg <= {acc_reg[0], q_reg[W-1:1]};
            end

            if (clr_g) begin
                g_reg <= 1'b0;
            end else if (write_g) begin
                g_reg <= q_reg[0];
            end
        end
    end

`ifdef ALP_DP_OVF_EN
    logic ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (clr_r0) begin
            ovf_reg <= 1'b0;
        end else if (write_r0 && (r0_inputmux_select == R0SRC_ALU)
                     && is_arith(alu_op) && ovf_w) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf          = ovf_reg;
    assign unused_flags = ovf_x;
`else
    assign ovf          = 1'b0;
    assign unused_flags = ovf_x ^ ovf_w;
`endif

    assign DATA_OUT               = R0_outputmux_select ? r1_reg : r0_reg;
    assign multiplication_control = {q_reg[0], g_reg};
    assign r0                     = |r0_reg;
    assign r1                     = |r1_reg;

endmodule
